instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/mips_pkg.sv | 72 +++++++
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_fifo.sv | 71 +++++++
 rtl/instr_encoder.sv | 93 +++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the instruction encoder: command op codes, MIPS
// opcode/funct fields, FSM state encoding, and the field-packing helper.
package mips_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 4;

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  // cmd_op codes; 10..15 are illegal
  localparam logic [3:0] CMD_NOP = 4'd0;
  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_BEQ = 4'd3;
  localparam logic [3:0] CMD_LW  = 4'd4;
  localparam logic [3:0] CMD_SW  = 4'd5;
  localparam logic [3:0] CMD_LUI = 4'd6;
  localparam logic [3:0] CMD_ORI = 4'd7;
  localparam logic [3:0] CMD_JR  = 4'd8;
  localparam logic [3:0] CMD_JAL = 4'd9;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_JR  = 6'b001000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_legal(input logic [3:0] op);
    return op <= CMD_JAL;
  endfunction

  // Fields an op does not use are simply not packed, so they never leak
  // into the encoded word.
  function automatic logic [DATA_W-1:0] encode(
    input logic [3:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [15:0] imm,
    input logic [25:0] target
  );
    logic [DATA_W-1:0] w;
    w = '0;
    case (op)
      CMD_ADD: w = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_ADD};
      CMD_SUB: w = {OPC_RTYPE, rs, rt, rd, 5'b0, FUNCT_SUB};
      CMD_JR:  w = {OPC_RTYPE, rs, 15'b0, FUNCT_JR};
      CMD_BEQ: w = {OPC_BEQ, rs, rt, imm};
      CMD_LW:  w = {OPC_LW, rs, rt, imm};
      CMD_SW:  w = {OPC_SW, rs, rt, imm};
      CMD_LUI: w = {OPC_LUI, 5'b0, rt, imm};
      CMD_ORI: w = {OPC_ORI, rs, rt, imm};
      CMD_JAL: w = {OPC_JAL, target};
      default: w = '0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Command and instruction-memory write bus of the instruction encoder.
//   cmd_*  : valid/ready command stream into the encoder
//   im_*   : we/ready write stream from the encoder to instruction memory
// master = command producer / memory side, slave = encoder.
interface instr_encoder_if;
  import mips_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_op;
  logic [4:0]        cmd_rs;
  logic [4:0]        cmd_rt;
  logic [4:0]        cmd_rd;
  logic [15:0]       cmd_imm;
  logic [25:0]       cmd_target;
  logic              im_we;
  logic              im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    output cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, im_ready,
    input  cmd_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_rs, cmd_rt, cmd_rd, cmd_imm, cmd_target, im_ready,
    output cmd_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/instr_fifo.sv
// 4 x 32 FIFO holding encoded words awaiting their IM write.
//   clk, reset : clock, synchronous active-high reset
//   flush      : empties the FIFO, wins over push/pop
//   push, din  : write an entry (ignored when full)
//   pop        : drop the head entry (ignored when empty)
//   dout       : head entry; full/empty status
module instr_fifo
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [1:0]        wr_ptr_q, wr_ptr_d;
  logic [1:0]        rd_ptr_q, rd_ptr_d;
  logic [2:0]        count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == 3'(FIFO_DEPTH));
  assign empty   = (count_q == 3'd0);
  assign dout    = mem_q[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + 2'd1;
      end
      if (pop_ok) rd_ptr_d = rd_ptr_q + 2'd1;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts MIPS-like commands, encodes them into 32-bit
// words, buffers them and writes them to consecutive IM word addresses.
//   clk, reset : clock, synchronous active-high reset
//   start      : restart at address base with an empty FIFO and clear err
//   base       : start address, sampled on start
//   bus        : command stream in, IM write stream out
//   done       : last IM address written
//   err        : sticky, an illegal command was accepted
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | after reset, waiting for start
// LOAD    | accepting commands and writing IM
// DONE    | address 1023 written, FIFO discarded, waiting for start
module instr_encoder
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  instr_encoder_if.slave    bus,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;

  logic              fifo_full, fifo_empty, fifo_flush, fifo_push;
  logic [DATA_W-1:0] fifo_dout;
  logic              in_load, accept, wr_done;

  assign in_load = (state_q == ST_LOAD);

  // start takes priority: it blocks both acceptance and write completion
  assign bus.cmd_ready = in_load && !fifo_full && !start;
  assign bus.im_we     = in_load && !fifo_empty;
  assign bus.im_addr   = addr_q;
  assign bus.im_wdata  = bus.im_we ? fifo_dout : '0;
  assign done          = (state_q == ST_DONE);
  assign err           = err_q;

  assign accept     = bus.cmd_valid && bus.cmd_ready;
  assign wr_done    = bus.im_we && bus.im_ready && !start;
  assign fifo_push  = accept && is_legal(bus.cmd_op);
  assign fifo_flush = start || (state_q == ST_DONE);

  instr_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .din   (encode(bus.cmd_op, bus.cmd_rs, bus.cmd_rt, bus.cmd_rd,
                   bus.cmd_imm, bus.cmd_target)),
    .pop   (wr_done),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_LOAD;
      addr_d  = base;
      err_d   = 1'b0;
    end else begin
      if (accept && !is_legal(bus.cmd_op)) err_d = 1'b1;
      if (state_q == ST_LOAD && wr_done) begin
        // the counter parks at the last address instead of wrapping
        if (addr_q == ADDR_LAST) state_d = ST_DONE;
        else                     addr_d  = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

endmodule
